// File: rtl/pe_stream_controller_if.sv
// Handshake bundle between the PE stream controller (master) and its datapath (slave).
// Flags flow into the controller; strobes and enables flow out.
interface pe_stream_controller_if #(
  parameter int unsigned FILTER_ADDR_WIDTH = 8,
  parameter int unsigned NUM_CH            = 4
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // datapath -> controller
  logic                         start;
  logic                         if_empty;
  logic [FILTER_ADDR_WIDTH-1:0] filter_waddr;
  logic                         sp_valid;
  logic                         data_stall;
  logic                         go_next_stride;
  logic                         stride_ended;
  logic                         go_next_filter;
  logic                         is_last_filter;
  logic                         f_co;
  logic                         psum_w_co;
  logic                         psum_valid;
  logic [1:0]                   wr_resp;
  logic                         error;

  // controller -> datapath
  logic                         chip_en;
  logic                         global_rst;
  logic                         en_p_traverse;
  logic                         pipe_adv;
  logic                         mult_en;
  logic                         ld_result;
  logic                         rst_f_counter;
  logic                         next_stride;
  logic                         next_filter;
  logic                         next_start;
  logic                         rst_if_ctx;
  logic                         psum_ren;
  logic                         wr_req;
  logic                         next_psum_waddr;
  logic [CH_W-1:0]              ch_idx;
  logic                         done;
  logic                         stall;

  modport master (
    input  start, if_empty, filter_waddr, sp_valid, data_stall,
           go_next_stride, stride_ended, go_next_filter, is_last_filter,
           f_co, psum_w_co, psum_valid, wr_resp, error,
    output chip_en, global_rst, en_p_traverse, pipe_adv, mult_en, ld_result,
           rst_f_counter, next_stride, next_filter, next_start, rst_if_ctx,
           psum_ren, wr_req, next_psum_waddr, ch_idx, done, stall
  );

  modport slave (
    output start, if_empty, filter_waddr, sp_valid, data_stall,
           go_next_stride, stride_ended, go_next_filter, is_last_filter,
           f_co, psum_w_co, psum_valid, wr_resp, error,
    input  chip_en, global_rst, en_p_traverse, pipe_adv, mult_en, ld_result,
           rst_f_counter, next_stride, next_filter, next_start, rst_if_ctx,
           psum_ren, wr_req, next_psum_waddr, ch_idx, done, stall
  );
endinterface

// File: rtl/pe_stream_controller.sv
// Sequencer for one PE convolution job: pipeline fill, filter sweep, psum read-modify-write
// per channel, with a sticky FAULT state that only reset clears.
module pe_stream_controller #(
  parameter int unsigned FILTER_ADDR_WIDTH = 8,
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned PIPE_DEPTH        = 2
) (
  input logic                    clk,
  input logic                    reset,
  pe_stream_controller_if.master bus
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned FILL_W = 4;

  localparam logic [CH_W-1:0]              LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [FILL_W-1:0]            FILL_LAST = FILL_W'(PIPE_DEPTH - 1);
  localparam logic [FILTER_ADDR_WIDTH-1:0] NO_FILTER = '0;

  typedef enum logic [3:0] {
    StIdle,
    StArm,
    StWaitData,
    StFindSp,
    StFill,
    StRun,
    StPsumAddr,
    StPsumRd,
    StPsumWr,
    StNextIf,
    StUpdateSp,
    StNextCh,
    StFinish,
    StFault
  } state_e;

  state_e            r_state;
  logic [CH_W-1:0]   r_ch_idx;
  logic [FILL_W-1:0] r_fill_cnt;
  logic              r_wr_issued;

  logic w_freeze;
  logic w_run;
  logic w_data_ready;
  logic w_wr_ok;
  logic w_wr_fault;
  logic w_last_filter;

  assign w_freeze      = bus.data_stall | ~bus.sp_valid;
  assign w_run         = ~w_freeze & ~bus.f_co;
  assign w_data_ready  = ~bus.if_empty & (bus.filter_waddr != NO_FILTER);
  assign w_wr_ok       = (bus.wr_resp == 2'b01);
  assign w_wr_fault    = bus.wr_resp[1];
  assign w_last_filter = bus.is_last_filter & bus.go_next_filter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_ch_idx    <= '0;
      r_fill_cnt  <= '0;
      r_wr_issued <= 1'b0;
    end else begin
      // Marks every PSUM_WR cycle after the first so wr_req fires once per visit.
      r_wr_issued <= (r_state == StPsumWr);
      if (bus.error && (r_state != StIdle)) begin
        r_state <= StFault;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (bus.start) r_state <= StArm;
          end
          StArm: begin
            if (!bus.start) r_state <= StWaitData;
          end
          StWaitData: begin
            if (w_data_ready) r_state <= StFindSp;
          end
          StFindSp: begin
            if (bus.sp_valid) begin
              r_fill_cnt <= '0;
              r_state    <= StFill;
            end
          end
          StFill: begin
            if (!w_freeze) begin
              r_fill_cnt <= r_fill_cnt + 4'd1;
              if (r_fill_cnt == FILL_LAST) r_state <= StRun;
            end
          end
          StRun: begin
            // Last-filter wrap wins even over a frozen pipeline.
            if (w_last_filter)  r_state <= StNextIf;
            else if (w_freeze)  r_state <= StRun;
            else if (bus.f_co)  r_state <= StPsumAddr;
          end
          StNextIf: begin
            r_state <= StUpdateSp;
          end
          StUpdateSp: begin
            r_state <= StRun;
          end
          StPsumAddr: begin
            // Channel 0 has no prior partial sum to accumulate onto.
            if (r_ch_idx == '0) r_state <= StPsumWr;
            else                r_state <= StPsumRd;
          end
          StPsumRd: begin
            if (bus.psum_valid) r_state <= StPsumWr;
          end
          StPsumWr: begin
            if (w_wr_fault) begin
              r_state <= StFault;
            end else if (w_wr_ok) begin
              if (!bus.psum_w_co)        r_state <= StRun;
              else if (r_ch_idx != LAST_CH) r_state <= StNextCh;
              else                       r_state <= StFinish;
            end
          end
          StNextCh: begin
            r_ch_idx <= r_ch_idx + CH_W'(1);
            r_state  <= StWaitData;
          end
          StFinish: begin
            r_ch_idx <= '0;
            r_state  <= StIdle;
          end
          StFault: begin
            r_state <= StFault;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.chip_en         = (r_state != StIdle);
    bus.global_rst      = 1'b0;
    bus.en_p_traverse   = 1'b0;
    bus.pipe_adv        = 1'b0;
    bus.mult_en         = 1'b0;
    bus.ld_result       = 1'b0;
    bus.rst_f_counter   = 1'b0;
    bus.next_stride     = 1'b0;
    bus.next_filter     = 1'b0;
    bus.next_start      = 1'b0;
    bus.rst_if_ctx      = 1'b0;
    bus.psum_ren        = 1'b0;
    bus.wr_req          = 1'b0;
    bus.next_psum_waddr = 1'b0;
    bus.done            = 1'b0;
    bus.stall           = 1'b0;
    bus.ch_idx          = r_ch_idx;
    unique case (r_state)
      StArm: begin
        bus.global_rst = 1'b1;
      end
      StFindSp: begin
        bus.en_p_traverse = ~bus.sp_valid;
      end
      StFill: begin
        // The first advance only primes the pipe; nothing valid to multiply yet.
        bus.pipe_adv = ~w_freeze;
        bus.mult_en  = ~w_freeze & (r_fill_cnt != '0);
      end
      StRun: begin
        bus.pipe_adv    = w_run;
        bus.mult_en     = w_run;
        bus.ld_result   = w_run;
        bus.next_stride = w_run & bus.go_next_stride & ~bus.stride_ended;
        bus.next_filter = ~w_freeze & bus.go_next_filter & ~bus.is_last_filter;
      end
      StPsumAddr: begin
        bus.rst_f_counter = 1'b1;
      end
      StPsumRd: begin
        bus.psum_ren = ~bus.psum_valid;
      end
      StPsumWr: begin
        bus.wr_req          = ~r_wr_issued;
        bus.next_psum_waddr = w_wr_ok;
      end
      StNextIf: begin
        bus.rst_if_ctx = 1'b1;
      end
      StUpdateSp: begin
        bus.next_start = 1'b1;
      end
      StNextCh: begin
        bus.rst_if_ctx = 1'b1;
      end
      StFinish: begin
        bus.done = 1'b1;
      end
      StFault: begin
        bus.stall = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
